regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, the next generation of the single-write, dual-read register file. It supports a configurable word width, depth, read-port count and write-port count, registered reads with optional write-to-read bypass, and a hardwired zero register. It also keeps a per-register pending scoreboard so issue logic can detect outstanding producers.

---
 rtl/mips_pkg.sv | 18 +
 rtl/regfile_wr_arb.sv | 59 +++++
 rtl/regfile_mp.sv | 137 +++++++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared register-file constants and packed-slice helpers
// Rev 1.0
// ============================================================================
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_ADDR  = 0;

   // Bit offset of element idx inside a flat vector of width-bit elements
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// regfile_wr_arb : per-address write-port priority resolve and read bypass pick
// Rev 1.0
// ============================================================================
module regfile_wr_arb
   import mips_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_WR   = 1,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [NUM_WR-1:0]                wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0]         wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0]         wr_data_i,
   input  logic [NUM_RD*ADDR_W-1:0]         rd_addr_i,
   output logic [(1<<ADDR_W)-1:0]           addr_we_o,
   output logic [(1<<ADDR_W)*DATA_W-1:0]    addr_wdata_o,
   output logic [NUM_RD-1:0]                byp_hit_o,
   output logic [NUM_RD*DATA_W-1:0]         byp_data_o
);

   localparam int DEPTH = 1 << ADDR_W;

   for (genvar a = 0; a < DEPTH; a++) begin : g_addr
      logic              w_we;
      logic [DATA_W-1:0] w_wd;

      // Later ports overwrite earlier matches, so the highest index wins
      always_comb begin
         w_we = 1'b0;
         w_wd = '0;
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
               w_we = 1'b1;
               w_wd = wr_data_i[slice_lo(p, DATA_W) +: DATA_W];
            end
         end
         if ((ZERO_REG != 0) && (a == ZERO_ADDR)) begin
            w_we = 1'b0;
         end
      end

      assign addr_we_o[a]                              = w_we;
      assign addr_wdata_o[slice_lo(a, DATA_W) +: DATA_W] = w_wd;
   end : g_addr

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;

      assign w_ra                                      = rd_addr_i[slice_lo(r, ADDR_W) +: ADDR_W];
      assign byp_hit_o[r]                              = addr_we_o[w_ra];
      assign byp_data_o[slice_lo(r, DATA_W) +: DATA_W] = addr_wdata_o[int'(w_ra) * DATA_W +: DATA_W];
   end : g_rd

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-port MIPS register file with bypass and pending scoreboard
// Rev 1.0
// ============================================================================
module regfile_mp
   import mips_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic [NUM_RD-1:0]          rd_pending,
   input  logic                       alloc_en,
   input  logic [ADDR_W-1:0]          alloc_addr,
   output logic [(1<<ADDR_W)-1:0]     pend_vec
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic [DEPTH-1:0]         pend_q, pend_d;
   logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
   logic [NUM_RD-1:0]        rd_pending_q, rd_pending_d;

   logic [DEPTH-1:0]         w_addr_we;
   logic [DEPTH*DATA_W-1:0]  w_addr_wdata;
   logic [NUM_RD-1:0]        w_byp_hit;
   logic [NUM_RD*DATA_W-1:0] w_byp_data;
   logic                     w_alloc_ok;

   regfile_wr_arb #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) u_wr_arb (
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .rd_addr_i    (rd_addr),
      .addr_we_o    (w_addr_we),
      .addr_wdata_o (w_addr_wdata),
      .byp_hit_o    (w_byp_hit),
      .byp_data_o   (w_byp_data)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int a = 0; a < DEPTH; a++) begin
            mem_q[a] <= '0;
         end
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            if (w_addr_we[a]) begin
               mem_q[a] <= w_addr_wdata[slice_lo(a, DATA_W) +: DATA_W];
            end
         end
      end
   end

   assign w_alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == ADDR_W'(ZERO_ADDR)));

   // Alloc is applied after the write clears: a new producer supersedes the old one
   always_comb begin
      pend_d = pend_q & ~w_addr_we;
      if (w_alloc_ok) begin
         pend_d[alloc_addr] = 1'b1;
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_zero;
      logic [DATA_W-1:0] w_rdat;
      logic              w_rpend;

      assign w_ra   = rd_addr[slice_lo(r, ADDR_W) +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_ra == ADDR_W'(ZERO_ADDR));

      always_comb begin
         w_rdat  = mem_q[w_ra];
         w_rpend = pend_q[w_ra];
         if (BYPASS != 0) begin
            w_rpend = pend_d[w_ra];
            if (w_byp_hit[r]) begin
               w_rdat = w_byp_data[slice_lo(r, DATA_W) +: DATA_W];
            end
         end
         if (w_zero) begin
            w_rdat  = '0;
            w_rpend = 1'b0;
         end
      end

      assign rd_data_d[slice_lo(r, DATA_W) +: DATA_W] =
         rd_en[r] ? w_rdat : rd_data_q[slice_lo(r, DATA_W) +: DATA_W];
      assign rd_pending_d[r] = rd_en[r] ? w_rpend : rd_pending_q[r];
   end : g_rd

   assign rd_valid_d = rd_en;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend_q       <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= '0;
         rd_pending_q <= '0;
      end else begin
         pend_q       <= pend_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign rd_pending = rd_pending_q;
   assign pend_vec   = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : directed bench, BYPASS=1 and BYPASS=0 instances side by side
// Rev 1.0
// ============================================================================
module tb_regfile_mp;

   logic        CLK;
   logic        RST;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic        alloc_en;
   logic [4:0]  alloc_addr;

   logic [63:0] b_rd_data,    n_rd_data;
   logic [1:0]  b_rd_valid,   n_rd_valid;
   logic [1:0]  b_rd_pending, n_rd_pending;
   logic [31:0] b_pend_vec,   n_pend_vec;

   int total = 0;
   int bad   = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .rd_pending(b_rd_pending), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .pend_vec(b_pend_vec)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_valid(n_rd_valid),
      .rd_pending(n_rd_pending), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .pend_vec(n_pend_vec)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_en      = '0;
      rd_addr    = '0;
      alloc_en   = 1'b0;
      alloc_addr = '0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*5 +: 5]   = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic rd(input int p, input logic [4:0] a);
      rd_en[p]          = 1'b1;
      rd_addr[p*5 +: 5] = a;
   endtask

   task automatic alloc(input logic [4:0] a);
      alloc_en   = 1'b1;
      alloc_addr = a;
   endtask

   initial begin
      RST = 1'b1;
      idle();
      step();
      step();
      chk("rst_valid",   64'(b_rd_valid), 64'h0);
      chk("rst_data",    b_rd_data,       64'h0);
      chk("rst_pend",    64'(b_pend_vec), 64'h0);
      RST = 1'b0;

      // Populate state so the mid-operation reset has something to clear
      wr(0, 5'd5, 32'h1111_1111);
      wr(1, 5'd31, 32'h2222_2222);
      alloc(5'd6);
      step();
      idle();
      chk("pre_pend6", 64'(b_pend_vec), 64'h0000_0040);
      step();

      #3;
      RST = 1'b1;
      rd(0, 5'd5);
      rd(1, 5'd31);
      wr(0, 5'd7, 32'h9999_9999);
      step();
      chk("rstmid_valid_b", 64'(b_rd_valid), 64'h0);
      chk("rstmid_valid_n", 64'(n_rd_valid), 64'h0);
      chk("rstmid_pend_b",  64'(b_pend_vec), 64'h0);
      chk("rstmid_pend_n",  64'(n_pend_vec), 64'h0);
      RST = 1'b0;
      idle();

      for (int a = 0; a < 32; a += 2) begin
         rd(0, 5'(a));
         rd(1, 5'(a + 1));
         step();
         chk($sformatf("rst_read_r%0d", a),     64'(b_rd_data[31:0]),  64'h0);
         chk($sformatf("rst_read_r%0d", a + 1), 64'(b_rd_data[63:32]), 64'h0);
      end
      chk("rst_read_valid", 64'(b_rd_valid), 64'h3);
      idle();

      // Basic write then read
      wr(0, 5'd5, 32'hDEAD_BEEF);
      step();
      idle();
      rd(0, 5'd5);
      rd(1, 5'd0);
      step();
      chk("basic_b", b_rd_data, 64'h0000_0000_DEAD_BEEF);
      chk("basic_n", n_rd_data, 64'h0000_0000_DEAD_BEEF);
      chk("basic_valid", 64'(b_rd_valid), 64'h3);
      idle();
      step();
      chk("hold_valid", 64'(b_rd_valid), 64'h0);
      chk("hold_data",  64'(b_rd_data[31:0]), 64'hDEAD_BEEF);

      // Same-cycle write and read of r7
      wr(0, 5'd7, 32'h1234_5678);
      rd(0, 5'd7);
      step();
      chk("byp_b", 64'(b_rd_data[31:0]), 64'h1234_5678);
      chk("byp_n", 64'(n_rd_data[31:0]), 64'h0);
      idle();
      rd(0, 5'd7);
      step();
      chk("after_byp_n", 64'(n_rd_data[31:0]), 64'h1234_5678);
      idle();

      // Both write ports hit r3: port 1 wins, including on the bypass path
      wr(0, 5'd3, 32'h0000_AAAA);
      wr(1, 5'd3, 32'h0000_BBBB);
      rd(1, 5'd3);
      step();
      chk("conf_byp_b", 64'(b_rd_data[63:32]), 64'h0000_BBBB);
      chk("conf_byp_n", 64'(n_rd_data[63:32]), 64'h0);
      idle();
      rd(0, 5'd3);
      step();
      chk("conf_b", 64'(b_rd_data[31:0]), 64'h0000_BBBB);
      chk("conf_n", 64'(n_rd_data[31:0]), 64'h0000_BBBB);
      idle();

      // Zero register ignores writes and allocs
      wr(1, 5'd0, 32'hFFFF_FFFF);
      alloc(5'd0);
      rd(0, 5'd0);
      step();
      chk("zero_byp_b",  64'(b_rd_data[31:0]), 64'h0);
      chk("zero_pend_b", 64'(b_pend_vec[0]),   64'h0);
      idle();
      rd(0, 5'd0);
      step();
      chk("zero_rd_b",    64'(b_rd_data[31:0]), 64'h0);
      chk("zero_rd_n",    64'(n_rd_data[31:0]), 64'h0);
      chk("zero_rdpend",  64'(b_rd_pending[0]), 64'h0);
      idle();

      // Scoreboard
      alloc(5'd9);
      rd(0, 5'd9);
      step();
      chk("alloc9_pend_b",  64'(b_pend_vec), 64'h0000_0200);
      chk("alloc9_pend_n",  64'(n_pend_vec), 64'h0000_0200);
      chk("alloc9_rdpend_b", 64'(b_rd_pending[0]), 64'h1);
      chk("alloc9_rdpend_n", 64'(n_rd_pending[0]), 64'h0);
      idle();

      wr(0, 5'd9, 32'h0000_0055);
      alloc(5'd9);
      step();
      chk("wr_alloc9_pend", 64'(b_pend_vec[9]), 64'h1);
      idle();

      wr(1, 5'd9, 32'h0000_0066);
      rd(0, 5'd9);
      step();
      chk("wr9_pend_b",    64'(b_pend_vec[9]),   64'h0);
      chk("wr9_pend_n",    64'(n_pend_vec[9]),   64'h0);
      chk("wr9_rdpend_b",  64'(b_rd_pending[0]), 64'h0);
      chk("wr9_rdpend_n",  64'(n_rd_pending[0]), 64'h1);
      chk("wr9_data_b",    64'(b_rd_data[31:0]), 64'h66);
      chk("wr9_data_n",    64'(n_rd_data[31:0]), 64'h55);
      idle();
      rd(0, 5'd9);
      step();
      chk("r9_data_n",   64'(n_rd_data[31:0]), 64'h66);
      chk("r9_rdpend_n", 64'(n_rd_pending[0]), 64'h0);
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
